// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Instruction-fetch stage. Owns the PC, issues word fetches to instruction
//   memory with at most one request outstanding, and buffers returned words in
//   a small FIFO that presents {instruction, instruction_address} to decode.
//   A redirect from execute flushes the FIFO and discards any in-flight
//   response.
//
// Ports
//   clk                 in   clock, rising edge
//   rst                 in   asynchronous active-low reset
//   jump_flag           in   redirect request from execute
//   jump_address [31:0] in   redirect target (bits [1:0] ignored)
//   stall               in   decode not accepting this cycle
//   imem_req            out  fetch request valid
//   imem_addr    [31:0] out  fetch address (current PC)
//   imem_ready          in   memory accepts request when high with imem_req
//   imem_rvalid         in   response valid, one per accepted request
//   imem_rdata   [31:0] in   response word
//   instruction  [31:0] out  FIFO head word, NOP (32'h13) when empty
//   instruction_address out  FIFO head PC, 0 when empty
//   instruction_valid   out  FIFO non-empty
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] ENTRY_ADDR = 32'h0000_1000,
    parameter int unsigned DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag,
    input  logic [31:0] jump_address,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instruction_address,
    output logic        instruction_valid
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [31:0]   r_pc;
    logic [31:0]   r_fetch_pc;
    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [63:0]   r_fifo [DEPTH];

    logic          w_push;
    logic          w_pop;
    logic          w_accept;
    logic          w_space;
    logic          w_issue_state;
    logic [CW-1:0] w_count_push;
    logic [31:0]   w_jump_target;
    logic [63:0]   w_head;

    always_comb begin
        w_jump_target = jump_address & 32'hFFFF_FFFC;
        w_push        = (r_state == S_WAIT) & imem_rvalid & ~jump_flag;
        w_pop         = instruction_valid & ~stall;
        // Space is reserved before issuing; a same-cycle pop is not credited.
        w_count_push  = r_count + CW'(w_push);
        w_space       = (w_count_push < DEPTH_C);
        w_issue_state = (r_state == S_IDLE) | ((r_state == S_WAIT) & imem_rvalid);
        // rst gates the request because the FSM sits in IDLE during reset.
        imem_req      = rst & ~jump_flag & w_issue_state & w_space;
        imem_addr     = r_pc;
        w_accept      = imem_req & imem_ready;
        w_head        = r_fifo[r_rd_ptr];
        instruction_valid   = (r_count != '0);
        instruction         = instruction_valid ? w_head[31:0]  : NOP;
        instruction_address = instruction_valid ? w_head[63:32] : '0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {r_fetch_pc, imem_rdata};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= ENTRY_ADDR;
            r_fetch_pc <= '0;
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (jump_flag) begin
            r_pc     <= w_jump_target;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            case (r_state)
                // An outstanding request must still have its response dropped.
                S_WAIT:    r_state <= imem_rvalid ? S_IDLE : S_DISCARD;
                S_DISCARD: r_state <= imem_rvalid ? S_IDLE : S_DISCARD;
                default:   r_state <= S_IDLE;
            endcase
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_pc;
                r_pc       <= r_pc + 32'd4;
                r_state    <= S_WAIT;
            end else begin
                case (r_state)
                    S_WAIT:    if (imem_rvalid) r_state <= S_IDLE;
                    S_DISCARD: if (imem_rvalid) r_state <= S_IDLE;
                    S_IDLE:    r_state <= S_IDLE;
                    default:   r_state <= S_IDLE;
                endcase
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule
